// File: rtl/pc_unit.sv
//==============================================================================
// Module   : pc_unit
// Purpose  : Program-counter stage: next-PC selection, BOOT/RUN/HALT sequencing,
//            sticky misaligned-jr flag. Optional retired-instruction counter is
//            built only when PC_RETIRE_CNT_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [1:0]  branchOp,
  input  logic [31:0] immExt,
  input  logic [25:0] jAddr,
  input  logic [31:0] rsData,
  input  logic        Zero,
  input  logic        Sign,
  input  logic        halt,
  output logic [31:0] curPC,
  output logic [31:0] PC4,
  output logic        halted,
  output logic        misaligned,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_halted;
  logic        r_misaligned;
  logic [31:0] w_pc4;
  logic [31:0] w_next_pc;
  logic        w_taken;
  logic        w_run;
  logic        w_retire;

  assign w_pc4 = r_pc + 32'd4;
  assign w_run = (r_state == ST_RUN);

  // A halt retires even when PCWre is low, since halt has priority.
  assign w_retire = w_run && (halt || PCWre);

  always_comb begin
    w_taken = 1'b0;
    case (branchOp)
      2'b00:   w_taken = Zero;
      2'b01:   w_taken = ~Zero;
      2'b10:   w_taken = Sign;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next_pc = w_pc4;
    case (PCSrc)
      2'b00:   w_next_pc = w_pc4;
      2'b01:   w_next_pc = w_taken ? (w_pc4 + {immExt[29:0], 2'b00}) : w_pc4;
      2'b10:   w_next_pc = {w_pc4[31:28], jAddr, 2'b00};
      default: w_next_pc = {rsData[31:2], 2'b00};
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_PC;
      r_halted     <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (halt) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (PCWre) begin
            r_pc <= w_next_pc;
            if ((PCSrc == 2'b11) && (rsData[1:0] != 2'b00)) begin
              r_misaligned <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

`ifdef PC_RETIRE_CNT_EN
  logic [31:0] r_retired;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_retired <= 32'd0;
    end else if (w_retire) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign retired = r_retired;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
  assign retired         = 32'd0;
`endif

  assign curPC      = r_pc;
  assign PC4        = w_pc4;
  assign halted     = r_halted;
  assign misaligned = r_misaligned;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
//==============================================================================
// Module   : tb_pc_unit
// Purpose  : Self-checking bench for pc_unit: directed scenarios followed by
//            randomized steps compared against a behavioural model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        PCWre = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [1:0]  branchOp = 2'b00;
  logic [31:0] immExt = 32'd0;
  logic [25:0] jAddr = 26'd0;
  logic [31:0] rsData = 32'd0;
  logic        Zero = 1'b0;
  logic        Sign = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] curPC;
  logic [31:0] PC4;
  logic        halted;
  logic        misaligned;
  logic [31:0] retired;

  pc_unit #(.RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc), .branchOp(branchOp),
    .immExt(immExt), .jAddr(jAddr), .rsData(rsData), .Zero(Zero), .Sign(Sign),
    .halt(halt), .curPC(curPC), .PC4(PC4), .halted(halted),
    .misaligned(misaligned), .retired(retired)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_errors = 0;

  // Behavioural model of the architectural state
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  bit          m_mis;
  bit          m_halted;
  bit          m_boot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_ret;
`ifdef PC_RETIRE_CNT_EN
    exp_ret = m_ret;
`else
    exp_ret = 32'd0;
`endif
    chk({tag, ".curPC"}, curPC, m_pc);
    chk({tag, ".PC4"}, PC4, m_pc + 32'd4);
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
    chk({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, m_mis});
    chk({tag, ".retired"}, retired, exp_ret);
  endtask

  function automatic logic [31:0] model_next(input logic [1:0] src, input logic [1:0] op,
                                             input logic [31:0] imm, input logic [25:0] ja,
                                             input logic [31:0] rs, input bit z, input bit s);
    logic [31:0] seq;
    bit          cond;
    seq = m_pc + 32'd4;
    cond = (op == 2'd0) ? z : (op == 2'd1) ? !z : (op == 2'd2) ? s : 1'b0;
    if (src == 2'd0) return seq;
    if (src == 2'd1) return cond ? seq + imm * 32'd4 : seq;
    if (src == 2'd2) return (seq & 32'hF000_0000) | ({6'd0, ja} * 32'd4);
    return rs & ~32'd3;
  endfunction

  task automatic step(input string tag, input bit we, input logic [1:0] src,
                      input logic [1:0] op, input logic [31:0] imm, input logic [25:0] ja,
                      input logic [31:0] rs, input bit z, input bit s, input bit h);
    logic [31:0] nxt;
    PCWre = we; PCSrc = src; branchOp = op; immExt = imm; jAddr = ja;
    rsData = rs; Zero = z; Sign = s; halt = h;
    nxt = model_next(src, op, imm, ja, rs, z, s);
    @(posedge CLK);
    if (m_halted) begin
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (h) begin
      m_halted = 1'b1;
      m_ret++;
    end else if (we) begin
      if (src == 2'd3 && rs[1:0] != 2'd0) m_mis = 1'b1;
      m_pc = nxt;
      m_ret++;
    end
    #1;
    check_all(tag);
  endtask

  task automatic seq(input string tag);
    step(tag, 1'b1, 2'd0, 2'd0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic jr(input string tag, input logic [31:0] rs);
    step(tag, 1'b1, 2'd3, 2'd0, 32'd0, 26'd0, rs, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic br(input string tag, input logic [1:0] op, input bit z, input bit s);
    step(tag, 1'b1, 2'd1, op, 32'hFFFF_FFFE, 26'd0, 32'd0, z, s, 1'b0);
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_ret = 32'd0; m_mis = 1'b0; m_halted = 1'b0; m_boot = 1'b1;
  endtask

  // Pulse Reset in the middle of a cycle; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    #2;
    Reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("por");
    @(negedge CLK);
    Reset = 1'b1;

    seq("boot");
    chk("boot_pc", curPC, 32'h0000_3000);
    seq("run1");
    chk("run1_pc", curPC, 32'h0000_3004);
    seq("run2");
    chk("run2_pc", curPC, 32'h0000_3008);
`ifdef PC_RETIRE_CNT_EN
    chk("run2_ret", retired, 32'd2);
`else
    chk("run2_ret", retired, 32'd0);
`endif

    jr("go100", 32'h100);  br("beq_t", 2'd0, 1'b1, 1'b0); chk("beq_t_pc", curPC, 32'h0FC);
    jr("go100", 32'h100);  br("beq_n", 2'd0, 1'b0, 1'b0); chk("beq_n_pc", curPC, 32'h104);
    jr("go100", 32'h100);  br("bltz",  2'd2, 1'b0, 1'b1); chk("bltz_pc",  curPC, 32'h0FC);
    jr("go100", 32'h100);  br("rsvd",  2'd3, 1'b1, 1'b1); chk("rsvd_pc",  curPC, 32'h104);

    jr("goJ", 32'h1000_0000);
    step("jmp", 1'b1, 2'd2, 2'd0, 32'd0, 26'h000_0040, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("jmp_pc", curPC, 32'h1000_0100);
    jr("goTop", 32'hFFFF_FFFC);
    chk("top_pc4", PC4, 32'h0);
    seq("wrap");
    chk("wrap_pc", curPC, 32'h0);

    jr("jr_mis", 32'h0000_2006);
    chk("jr_mis_pc", curPC, 32'h0000_2004);
    chk("jr_mis_flag", {31'd0, misaligned}, 32'd1);
    jr("jr_ok", 32'h0000_0200);
    chk("mis_sticky", {31'd0, misaligned}, 32'd1);

    for (int i = 0; i < 3; i++)
      step("stall", 1'b0, 2'd3, 2'd0, 32'd0, 26'd0, 32'h4, 1'b0, 1'b0, 1'b0);
    chk("stall_pc", curPC, 32'h200);
    step("halt", 1'b1, 2'd2, 2'd0, 32'd0, 26'h3FF, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("halt_pc", curPC, 32'h200);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 3; i++)
      step("halted", 1'b1, 2'd3, 2'd0, 32'd0, 26'd0, 32'h7, 1'b0, 1'b0, 1'b0);
    do_reset("rst_halt");

    for (int i = 0; i < 400; i++) begin
      logic [31:0] rs;
      logic [31:0] imm;
      rs  = $urandom;
      if ($urandom_range(3) != 0) rs[1:0] = 2'b00;
      imm = ($urandom_range(1) == 0) ? $urandom : 32'($signed($urandom_range(64)) - 32);
      step("rand", $urandom_range(9) != 0, 2'($urandom_range(3)), 2'($urandom_range(3)),
           imm, 26'($urandom), rs, 1'($urandom), 1'($urandom), $urandom_range(39) == 0);
      if (m_halted && $urandom_range(3) == 0) do_reset("rst_rand_halt");
      else if ($urandom_range(99) == 0) do_reset("rst_rand_run");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Program-counter stage of the single-cycle CPU, sitting directly downstream of the ALU. It consumes the ALU `Zero`/`Sign` flags together with decoded control to resolve branches, jumps and register jumps. It holds the architectural PC, feeds instruction fetch and the link path, and sequences boot, run and halt states. A retired-instruction counter is provided as a compile-time option.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `CLK` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-low reset.
- `PCWre` in 1: PC write enable; 0 holds the PC for this cycle.
- `PCSrc` in 2: 00 sequential, 01 conditional branch, 10 jump (j/jal), 11 register jump (jr).
- `branchOp` in 2: 00 beq (taken if `Zero`), 01 bne (taken if !`Zero`), 10 bltz (taken if `Sign`), 11 reserved (never taken).
- `immExt` in 32: sign-extended branch offset, in words.
- `jAddr` in 26: jump target field.
- `rsData` in 32: register-jump target.
- `Zero`, `Sign` in 1 each: ALU flags for the current instruction.
- `halt` in 1: current instruction is halt.
- `curPC` out 32: registered current PC.
- `PC4` out 32: combinational `curPC`+4, used as the link value.
- `halted` out 1: high in the HALT state.
- `misaligned` out 1: sticky; set when a register-jump target has nonzero bits [1:0].
- `retired` out 32: count of retired instructions (see Configuration).

## Operation
- State machine with three states: BOOT, RUN and HALT. Reset enters BOOT.
- **BOOT:** lasts exactly one clock edge. The PC holds `RESET_PC`, `retired` is not incremented, and the state moves to RUN. All inputs are ignored.
- **RUN, next-PC selection** (combinational, all additions modulo 2^32):
  - `PCSrc`=00: `PC4`.
  - `PCSrc`=01: `PC4` + (`immExt`<<2) if the condition selected by `branchOp` holds; otherwise `PC4`.
  - `PCSrc`=10: {`PC4`[31:28], `jAddr`, 2'b00}.
  - `PCSrc`=11: `rsData` with bits [1:0] forced to 0. If `rsData`[1:0]≠0, set `misaligned`.
- **RUN, edge behaviour:**
  - `PCWre`=1 and `halt`=0: `curPC` <= next PC and `retired`++.
  - `PCWre`=0 and `halt`=0: PC and `retired` hold.
  - `halt`=1: state goes to HALT, the PC holds at the halt instruction's address, and `retired`++. `halt` takes priority over `PCWre`.
- **HALT:** absorbing. The PC, `retired` and `misaligned` are frozen until `Reset` is asserted. `halted`=1.
- **Wrap-around:**
  - `PC4` at 0xFFFF_FFFC is 0x0000_0000.
  - Branch targets wrap modulo 2^32.
  - `retired` wraps from 0xFFFF_FFFF to 0.
- `misaligned` is updated only on an edge where the PC is actually written (RUN, `PCWre`=1, `halt`=0).

## Timing
- All state, `curPC`, `misaligned` and `retired` update on the rising edge of `CLK`.
- `PC4` and the next-PC mux are combinational from `curPC` and the inputs in the same cycle. `Zero`/`Sign` need only meet setup to the edge; they arrive from the ALU in the same cycle.
- Latency: a taken branch or jump appears on `curPC` one edge after the instruction is presented. There is no delay slot.
- Reset values: `curPC`=`RESET_PC`, `halted`=0, `misaligned`=0, `retired`=0, state=BOOT.
- Reset asserted mid-operation, including in HALT, forces these values immediately, independent of `CLK`.
- The first PC advance occurs on the second rising edge after `Reset` deasserts.

## Configuration
- Macro: `PC_RETIRE_CNT_EN`.
- **Defined:** the 32-bit `retired` counter is implemented exactly as described above.
- **Undefined:** no counter register is built, and `retired` is tied to 32'h0. All other behaviour is unchanged.

## Test plan
- **Reset and boot:** `RESET_PC`=0x0000_3000; release `Reset`; `PCSrc`=00, `PCWre`=1 -> `curPC` is 0x3000 after edge 1, then 0x3004 and 0x3008; `retired`=2 after edge 3.
- **Branches:** at PC 0x100, `PCSrc`=01, `immExt`=0xFFFF_FFFE (-2):
  - beq with `Zero`=1 -> next PC 0x0FC.
  - beq with `Zero`=0 -> 0x104.
  - bltz with `Sign`=1 -> 0x0FC.
  - `branchOp`=11 -> 0x104.
- **Jumps and wrap:**
  - At PC 0x1000_0000, `PCSrc`=10, `jAddr`=0x000_0040 -> next PC 0x1000_0100.
  - At PC 0xFFFF_FFFC, `PCSrc`=00 -> next PC 0x0.
- **Register jump:** `PCSrc`=11, `rsData`=0x0000_2006 -> next PC 0x0000_2004 and `misaligned`=1. The flag stays 1 after a subsequent aligned jr.
- **Halt priority and stall:**
  - `PCWre`=0 for 3 edges -> PC and `retired` are unchanged.
  - `halt`=1 with `PCWre`=1 at PC 0x200 -> `halted`=1, the PC stays at 0x200, and `retired`+1. Further edges change nothing.
  - Asynchronous `Reset` pulse mid-cycle -> all outputs return to their reset values before the next edge.
- **Config:** build without `PC_RETIRE_CNT_EN` -> `retired`=0 throughout the first scenario; the PC sequence is identical.
